// File: rtl/decompressor.sv
`default_nettype none
// ============================================================================
// Module   : decompressor
// Purpose  : Rebuilds 256-bit blocks from a per-block 16-bit tag stream and a
//            byte-packed payload stream, and holds each rebuilt block in an
//            output register until the downstream reader consumes it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    asynchronous active-low reset
//   tag_in       in   16   block tag, bits [2i+1:2i] code word i
//   tag_push     in   1    write tag_in into the tag FIFO
//   tag_full     out  1    tag FIFO holds TAG_DEPTH entries
//   data_in      in   256  payload beat, byte 0 = data_in[7:0]
//   push_infifo  in   1    append the 32 bytes of data_in to the staging buffer
//   data_full    out  1    staging buffer holds more than 32 bytes
//   rdEn         in   1    downstream consumes data_out this cycle
//   data_out     out  256  rebuilt block, word i = data_out[32i+31:32i]
//   out_valid    out  1    data_out holds an unconsumed block
//   err          out  1    sticky, a tag or beat push was dropped
// Build option
//   DECOMP_SIGN_EXT_EN : when defined, code 10 sign-extends its byte;
//                        otherwise the byte is zero-extended.
// ============================================================================
module decompressor #(
  parameter int TAG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  tag_in,
  input  logic         tag_push,
  output logic         tag_full,
  input  logic [255:0] data_in,
  input  logic         push_infifo,
  output logic         data_full,
  input  logic         rdEn,
  output logic [255:0] data_out,
  output logic         out_valid,
  output logic         err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(TAG_DEPTH);

  // Tag FIFO
  logic [15:0]      tag_mem_q [TAG_DEPTH];
  logic [15:0]      tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;
  logic             tag_full_q, tag_full_d;

  // Staging buffer, byte 0 (oldest) in bits [7:0]
  logic [511:0]     buf_q, buf_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             data_full_q, data_full_d;

  // Output side
  logic [255:0]     data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      prev_q, prev_d;
  logic             err_q, err_d;

  // Decode datapath
  logic [15:0]      head_tag;
  logic [5:0]       need;
  logic [255:0]     dec_block;
  logic [31:0]      word, word_prev, lit, ext;
  logic             fire, tag_acc, data_acc;
  logic [5:0]       need_pop;
  logic [6:0]       wr_off;
  logic [8:0]       wr_bit;

  // Combinational block decode of the head tag against the staging buffer.
  // Words are decoded in order so that byte offsets and the repeat source
  // chain naturally through the loop.
  always_comb begin
    head_tag  = tag_mem_q[rd_ptr_q];
    need      = '0;
    word_prev = prev_q;
    dec_block = '0;
    word      = '0;
    lit       = '0;
    ext       = '0;
    for (int i = 0; i < 8; i++) begin
      lit = buf_q[{need, 3'b000} +: 32];
`ifdef DECOMP_SIGN_EXT_EN
      ext = {{24{lit[7]}}, lit[7:0]};
`else
      ext = {24'h000000, lit[7:0]};
`endif
      case (head_tag[2*i +: 2])
        2'b00:   word = '0;
        2'b01:   word = word_prev;
        2'b10: begin
          word = ext;
          need = need + 6'd1;
        end
        default: begin
          word = lit;
          need = need + 6'd4;
        end
      endcase
      dec_block[32*i +: 32] = word;
      word_prev = word;
    end
  end

  always_comb begin
    fire     = (tag_cnt_q != '0) && ({1'b0, need} <= cnt_q) && (!out_valid_q || rdEn);
    // A full FIFO still takes a push when the head is popped on the same edge.
    tag_acc  = tag_push && (!tag_full_q || fire);
    data_acc = push_infifo && !data_full_q;
    need_pop = fire ? need : 6'd0;
  end

  // Tag FIFO next state
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    if (tag_acc) begin
      tag_mem_d[wr_ptr_q] = tag_in;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
    if (fire) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({tag_acc, fire})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_ONE;
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_ONE;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    tag_full_d = (tag_cnt_d == CNT_DEPTH);
  end

  // Staging buffer next state. The consumed bytes are shifted out first, so a
  // beat accepted on the same edge lands right after the surviving bytes.
  always_comb begin
    buf_d  = buf_q >> {need_pop, 3'b000};
    wr_off = cnt_q - {1'b0, need_pop};
    wr_bit = 9'({wr_off, 3'b000});
    if (data_acc) begin
      buf_d[wr_bit +: 256] = data_in;
    end
    cnt_d       = cnt_q - {1'b0, need_pop} + (data_acc ? 7'd32 : 7'd0);
    data_full_d = (cnt_d > 7'd32);
  end

  // Output register and status next state
  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    prev_d      = prev_q;
    if (fire) begin
      data_out_d  = dec_block;
      out_valid_d = 1'b1;
      prev_d      = dec_block[255:224];
    end else if (rdEn) begin
      out_valid_d = 1'b0;
    end
    err_d = err_q | (tag_push && !tag_acc) | (push_infifo && data_full_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
      tag_full_q  <= 1'b0;
      buf_q       <= '0;
      cnt_q       <= '0;
      data_full_q <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      prev_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      tag_full_q  <= tag_full_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      data_full_q <= data_full_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      prev_q      <= prev_d;
      err_q       <= err_d;
    end
  end

  assign tag_full  = tag_full_q;
  assign data_full = data_full_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : tb_decompressor
// Purpose  : Self-checking bench for decompressor. A queue-based model of the
//            tag FIFO, byte stream and output register predicts every output
//            after each clock edge; directed cases cover reset, a literal
//            block and tag backpressure, followed by random traffic.
// Revision : 1.0 - initial release
// Build option: honours DECOMP_SIGN_EXT_EN the same way as the design.
// ============================================================================
module tb_decompressor;

  localparam int TAG_DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  tag_in;
  logic         tag_push;
  logic         tag_full;
  logic [255:0] data_in;
  logic         push_infifo;
  logic         data_full;
  logic         rdEn;
  logic [255:0] data_out;
  logic         out_valid;
  logic         err;

  decompressor #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tag_in     (tag_in),
    .tag_push   (tag_push),
    .tag_full   (tag_full),
    .data_in    (data_in),
    .push_infifo(push_infifo),
    .data_full  (data_full),
    .rdEn       (rdEn),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0]  m_tags[$];
  logic [7:0]   m_bytes[$];
  logic [255:0] m_dout;
  logic         m_ov;
  logic         m_err;
  logic [31:0]  m_prev;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int need_of(input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (t[2*i +: 2] == 2'b10) n += 1;
      if (t[2*i +: 2] == 2'b11) n += 4;
    end
    return n;
  endfunction

  task automatic model_clear();
    m_tags.delete();
    m_bytes.delete();
    m_dout = '0;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    m_prev = '0;
  endtask

  // Decode the head tag, consuming bytes from the front of the stream.
  task automatic model_decode();
    logic [15:0]  t;
    logic [31:0]  w;
    logic [7:0]   b0, b1, b2, b3;
    logic [255:0] blk;
    t   = m_tags.pop_front();
    blk = '0;
    for (int i = 0; i < 8; i++) begin
      case (t[2*i +: 2])
        2'b00: w = 32'd0;
        2'b01: w = m_prev;
        2'b10: begin
          b0 = m_bytes.pop_front();
          w  = {24'd0, b0};
`ifdef DECOMP_SIGN_EXT_EN
          if (b0 >= 8'd128) w = w + 32'hFFFFFF00;
`endif
        end
        default: begin
          b0 = m_bytes.pop_front();
          b1 = m_bytes.pop_front();
          b2 = m_bytes.pop_front();
          b3 = m_bytes.pop_front();
          w  = {b3, b2, b1, b0};
        end
      endcase
      blk[32*i +: 32] = w;
      m_prev = w;
    end
    m_dout = blk;
    m_ov   = 1'b1;
  endtask

  task automatic check_all();
    check("out_valid", out_valid, m_ov);
    check("data_out",  data_out,  m_dout);
    check("err",       err,       m_err);
    check("tag_full",  tag_full,  m_tags.size() == TAG_DEPTH);
    check("data_full", data_full, m_bytes.size() > 32);
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input logic tp, input logic [15:0] ti, input logic pd,
                      input logic [255:0] di, input logic rd);
    bit fire, tacc, dacc;
    @(negedge clk);
    tag_push = tp; tag_in = ti; push_infifo = pd; data_in = di; rdEn = rd;
    fire = 1'b0;
    if (m_tags.size() > 0) begin
      if (m_bytes.size() >= need_of(m_tags[0]) && (!m_ov || rd)) fire = 1'b1;
    end
    tacc = tp && (m_tags.size() < TAG_DEPTH || fire);
    dacc = pd && (m_bytes.size() <= 32);
    if ((tp && !tacc) || (pd && !dacc)) m_err = 1'b1;
    if (fire) model_decode();
    else if (rd) m_ov = 1'b0;
    if (tacc) m_tags.push_back(ti);
    if (dacc) for (int k = 0; k < 32; k++) m_bytes.push_back(di[8*k +: 8]);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    tag_push = 1'b0; tag_in = '0; push_infifo = 1'b0; data_in = '0; rdEn = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out",  data_out,  256'd0);
    check("rst_err",       err,       1'b0);
    check("rst_tag_full",  tag_full,  1'b0);
    check("rst_data_full", data_full, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [255:0] rand_beat();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    logic [255:0] lit;
    logic [255:0] exp_blk;
    logic         tp, pd, rd;
    logic [15:0]  ti;
    int           rdpct;

    idle_inputs();
    model_clear();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Literal block: bytes 0x00..0x1F
    for (int k = 0; k < 32; k++) lit[8*k +: 8] = 8'(k);
    exp_blk = '0;
    for (int w = 0; w < 8; w++)
      exp_blk[32*w +: 32] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    step(1'b1, 16'hFFFF, 1'b1, lit, 1'b0);
    check("lit_not_yet_valid", out_valid, 1'b0);
    step(1'b0, 16'h0000, 1'b0, '0, 1'b0);
    check("lit_valid", out_valid, 1'b1);
    check("lit_block", data_out, exp_blk);
    check("lit_data_full", data_full, 1'b0);

    // Repeat code: one literal then seven repeats
    lit = '0;
    lit[31:0] = 32'hFEDCBA98;
    step(1'b1, 16'h5557, 1'b1, lit, 1'b1);
    step(1'b1, 16'h0000, 1'b0, '0, 1'b1);
    check("rep_block", data_out, {8{32'hFEDCBA98}});
    step(1'b0, 16'h0000, 1'b0, '0, 1'b1);
    check("rep_zero_block", data_out, 256'd0);

    // Backpressure: fill the tag FIFO with rdEn low, then overflow it
    for (int k = 0; k < TAG_DEPTH + 3; k++) step(1'b1, 16'h0000, 1'b0, '0, 1'b0);
    check("bp_err", err, 1'b1);
    check("bp_tag_full", tag_full, 1'b1);
    for (int k = 0; k < TAG_DEPTH + 1; k++) step(1'b0, 16'h0000, 1'b0, '0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, '0, 1'b0);
    check("bp_drained", out_valid, 1'b0);

    // Reset mid-stream with state queued
    step(1'b1, 16'hFFFF, 1'b1, rand_beat(), 1'b0);
    step(1'b1, 16'h0000, 1'b0, '0, 1'b0);
    do_reset();
    step(1'b1, 16'h0000, 1'b0, '0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, '0, 1'b1);
    check("post_rst_zero", data_out, 256'd0);

    // Random traffic that respects flow control
    for (int c = 0; c < 1200; c++) begin
      tp = ($urandom_range(0, 3) != 0) && (m_tags.size() < TAG_DEPTH);
      ti = 16'($urandom());
      if ($urandom_range(0, 4) == 0) ti = ti & 16'h5555;
      pd = ($urandom_range(0, 1) == 1) && (m_bytes.size() <= 32);
      rd = ($urandom_range(0, 9) < 7);
      step(tp, ti, pd, rand_beat(), rd);
    end

    // Random traffic ignoring flow control, varying read pressure
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      rdpct = (c / 200) % 2 == 0 ? 8 : 2;
      tp = ($urandom_range(0, 2) != 0);
      ti = 16'($urandom());
      pd = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 9) < rdpct);
      step(tp, ti, pd, rand_beat(), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decompressor.md
# decompressor

Receive-side counterpart of the compressor. It takes the compressor's two output streams: a 16-bit tag per block (2 bits per 32-bit word) and a byte-packed payload stream in 256-bit beats. It rebuilds each original 256-bit block and presents it on a held output register with a downstream read handshake. It sits at the consumer end of the compressed link, before the data sink.

## Interface
- TAG_DEPTH, 4: depth of the tag FIFO, in blocks (≥2, power of two).
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tag_in  input  16  block tag; bits [2i+1:2i] code word i.
- tag_push  input  1  write tag_in into the tag FIFO.
- tag_full  output  1  tag FIFO holds TAG_DEPTH entries.
- data_in  input  256  payload beat; byte 0 = data_in[7:0], stream order ascending.
- push_infifo  input  1  append all 32 bytes of data_in to the staging buffer.
- data_full  output  1  staging buffer count > 32; beat cannot be accepted.
- rdEn  input  1  downstream consumes data_out this cycle.
- data_out  output  256  reconstructed block; word i = data_out[32i+31:32i].
- out_valid  output  1  data_out holds an unconsumed block.
- err  output  1  sticky: a push was dropped (tag or data overflow).

## Operation
- Tag codes per word, with payload bytes consumed:
  - 00: zero word, 0 bytes.
  - 01: repeat of the previous word, 0 bytes.
  - 10: one byte, extended to 32 bits, 1 byte.
  - 11: literal, 4 bytes little-endian, 4 bytes.
- "Previous word" is word i-1 of the same block. For word 0 it is word 7 of the last decoded block; this register is 0 after reset.
- Words are decoded in order 0 to 7, and payload bytes are taken in stream order. need = Σ bytes over the 8 words, 0..32.
- Staging buffer: 64 bytes plus count cnt (0..64, 7 bits). Bytes are left-justified, so byte 0 is the oldest.
- Accept rule: a beat is accepted when push_infifo=1 and data_full=0. The accepted beat is written at offset cnt−need_pop, where need_pop is the need of the block decoded that cycle, else 0.
- Decode fires when all of the following hold:
  - the tag FIFO is not empty;
  - cnt ≥ need(head tag);
  - out_valid=0 or rdEn=1.
- On a decode:
  - pop the head tag;
  - shift the buffer down by need;
  - cnt ← cnt − need (+32 if a beat is accepted the same cycle);
  - load data_out, set out_valid, update the previous-word register.
- rdEn with no decode clears out_valid. rdEn while out_valid=0 is ignored.
- Tag FIFO: pointer wrap at TAG_DEPTH. A push and a pop in the same cycle while full is allowed, and tag_full stays asserted.
- Overflow: tag_push while tag_full, or push_infifo while data_full, drops the input and sets err. err clears only on reset.
- Payload bytes left unused past a block stay buffered for the next block.

## Timing
- Reset values: data_out=0, out_valid=0, tag_full=0, data_full=0, err=0, cnt=0, tag FIFO empty, previous word=0. All are forced immediately on reset assertion. Reset mid-block discards all buffered tags and bytes.
- There is no bypass. A tag or beat pushed at edge E0 can first be decoded at edge E1, so out_valid rises after E1.
- Throughput: one block per cycle when the inputs and rdEn allow it.
- data_out is stable while out_valid=1 and rdEn=0.
- tag_full and data_full are registered and reflect state after the last edge.

## Configuration
- DECOMP_SIGN_EXT_EN defined: code 10 sign-extends the byte (bit 7 replicated into [31:8]).
- DECOMP_SIGN_EXT_EN undefined: code 10 zero-extends the byte.
- The compressor must be built with the matching setting.

## Test plan
- Reset: assert reset mid-stream with blocks queued → all outputs 0 immediately; after release, tag 16'h0000 produces a 256'h0 block.
- Literals: tag 16'hFFFF plus one beat with bytes 0x00..0x1F → data_out word0=32'h03020100 … word7=32'h1F1E1D1C; out_valid two edges after the push; cnt returns to 0.
- Repeat: tag 16'h5557 plus beat bytes 98 BA DC FE (rest 0) → all eight words 32'hFEDCBA98; 28 leftover bytes stay buffered; the next tag 16'h0000 yields 256'h0.
- Byte code: tag 16'hAAAA plus bytes 0x80,0x01,… → word0=32'h00000080 without DECOMP_SIGN_EXT_EN, 32'hFFFFFF80 with it; word1=32'h00000001 in both builds.
- Cross-beat: two tags 16'hFFF0, 24 bytes each, spread over two beats → the second block's bytes are split across the beat boundary and are reconstructed exactly; data_full behaves correctly at cnt=40.
- Backpressure: hold rdEn=0 and push 16'h0000 tags until tag_full=1, then one more push → err=1, data_out holds the first block; pulsing rdEn TAG_DEPTH+1 times drains the output register and the tag FIFO, giving TAG_DEPTH+1 zero blocks.
